// File: rtl/execute_pkg.sv
// Shared RV32I pipeline encodings: one-hot ALU ops, one-hot opcode classes and exception bits.
// Used by decode, execute and memoryaccess so that all stages agree on bit positions.
package execute_pkg;

    localparam int ALU_WIDTH = 16;
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_XOR  = 4;
    localparam int ALU_OR   = 5;
    localparam int ALU_AND  = 6;
    localparam int ALU_SLL  = 7;
    localparam int ALU_SRL  = 8;
    localparam int ALU_SRA  = 9;
    localparam int ALU_EQ   = 10;
    localparam int ALU_NEQ  = 11;
    localparam int ALU_LT   = 12;
    localparam int ALU_GE   = 13;
    localparam int ALU_LTU  = 14;
    localparam int ALU_GEU  = 15;

    localparam int OPCODE_WIDTH = 11;
    localparam int OP_RTYPE  = 0;
    localparam int OP_ITYPE  = 1;
    localparam int OP_LOAD   = 2;
    localparam int OP_STORE  = 3;
    localparam int OP_BRANCH = 4;
    localparam int OP_JAL    = 5;
    localparam int OP_JALR   = 6;
    localparam int OP_LUI    = 7;
    localparam int OP_AUIPC  = 8;
    localparam int OP_SYSTEM = 9;
    localparam int OP_FENCE  = 10;

    localparam int EXCEPTION_WIDTH = 4;
    localparam int EXC_ILLEGAL    = 0;
    localparam int EXC_ECALL      = 1;
    localparam int EXC_EBREAK     = 2;
    localparam int EXC_MISALIGNED = 3;

    typedef logic [ALU_WIDTH-1:0]       alu_t;
    typedef logic [OPCODE_WIDTH-1:0]    opcode_t;
    typedef logic [EXCEPTION_WIDTH-1:0] exc_t;

    // Opcode-class masks: which classes write rd, read rs1, read rs2, take op_b from imm.
    localparam opcode_t RD_WRITERS = opcode_t'((1 << OP_RTYPE) | (1 << OP_ITYPE) | (1 << OP_LOAD) |
                                               (1 << OP_JAL) | (1 << OP_JALR) | (1 << OP_LUI) |
                                               (1 << OP_AUIPC));
    localparam opcode_t RS1_READERS = opcode_t'((1 << OP_RTYPE) | (1 << OP_ITYPE) | (1 << OP_LOAD) |
                                                (1 << OP_STORE) | (1 << OP_BRANCH) | (1 << OP_JALR));
    localparam opcode_t RS2_READERS = opcode_t'((1 << OP_RTYPE) | (1 << OP_STORE) | (1 << OP_BRANCH));
    localparam opcode_t IMM_OPERAND = opcode_t'((1 << OP_ITYPE) | (1 << OP_LOAD) | (1 << OP_STORE) |
                                                (1 << OP_JALR));

endpackage

// File: rtl/execute_if.sv
// Execute-stage bus: decode fields, regfile data, forwarding taps, results and pipeline control.
// master = surrounding pipeline, slave = execute.
interface execute_if
    import execute_pkg::*;
#(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] decode_pc;
    logic [4:0]      decode_rs1;
    logic [4:0]      decode_rs2;
    logic [4:0]      decode_rd;
    logic [XLEN-1:0] decode_imm;
    logic [2:0]      decode_funct3;
    alu_t            decode_alu_type;
    opcode_t         decode_opcode_type;
    exc_t            decode_exception;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    logic [4:0]      memoryaccess_rd;
    logic            memoryaccess_wr_rd;
    logic            memoryaccess_is_load;
    logic [XLEN-1:0] memoryaccess_rd_data;
    logic [4:0]      writeback_rd;
    logic            writeback_wr_rd;
    logic [XLEN-1:0] writeback_rd_data;

    logic [XLEN-1:0] execute_pc;
    logic [4:0]      execute_rd;
    logic            execute_wr_rd;
    logic [XLEN-1:0] execute_rd_data;
    logic [XLEN-1:0] execute_result;
    logic [XLEN-1:0] execute_rs2_data;
    logic [2:0]      execute_funct3;
    opcode_t         execute_opcode_type;
    exc_t            execute_exception;
    logic            execute_change_pc;
    logic [XLEN-1:0] execute_next_pc;

    logic            clk_en;
    logic            next_clk_en;
    logic            stall;
    logic            next_stall;
    logic            flush;
    logic            next_flush;

    modport master (
        output decode_pc, decode_rs1, decode_rs2, decode_rd, decode_imm, decode_funct3,
               decode_alu_type, decode_opcode_type, decode_exception, rs1_data, rs2_data,
               memoryaccess_rd, memoryaccess_wr_rd, memoryaccess_is_load, memoryaccess_rd_data,
               writeback_rd, writeback_wr_rd, writeback_rd_data, clk_en, stall, flush,
        input  execute_pc, execute_rd, execute_wr_rd, execute_rd_data, execute_result,
               execute_rs2_data, execute_funct3, execute_opcode_type, execute_exception,
               execute_change_pc, execute_next_pc, next_clk_en, next_stall, next_flush
    );

    modport slave (
        input  decode_pc, decode_rs1, decode_rs2, decode_rd, decode_imm, decode_funct3,
               decode_alu_type, decode_opcode_type, decode_exception, rs1_data, rs2_data,
               memoryaccess_rd, memoryaccess_wr_rd, memoryaccess_is_load, memoryaccess_rd_data,
               writeback_rd, writeback_wr_rd, writeback_rd_data, clk_en, stall, flush,
        output execute_pc, execute_rd, execute_wr_rd, execute_rd_data, execute_result,
               execute_rs2_data, execute_funct3, execute_opcode_type, execute_exception,
               execute_change_pc, execute_next_pc, next_clk_en, next_stall, next_flush
    );

endinterface

// File: rtl/execute_alu.sv
// Combinational RV32I ALU with one-hot op select; compare ops also drive the 1-bit cmp flag.
// Zero latency, no flow control.
module execute_alu
    import execute_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  alu_t            alu_type,
    output logic [XLEN-1:0] result,
    output logic            cmp
);

    logic [4:0] shamt;
    logic       eq;
    logic       lt_s;
    logic       lt_u;

    assign shamt = op_b[4:0];
    assign eq    = (op_a == op_b);
    assign lt_s  = ($signed(op_a) < $signed(op_b));
    assign lt_u  = (op_a < op_b);

    always_comb begin
        cmp = 1'b0;
        case (1'b1)
            alu_type[ALU_EQ]:  cmp = eq;
            alu_type[ALU_NEQ]: cmp = !eq;
            alu_type[ALU_LT]:  cmp = lt_s;
            alu_type[ALU_GE]:  cmp = !lt_s;
            alu_type[ALU_LTU]: cmp = lt_u;
            alu_type[ALU_GEU]: cmp = !lt_u;
            default:           cmp = 1'b0;
        endcase
    end

    always_comb begin
        result = '0;
        case (1'b1)
            alu_type[ALU_ADD]:  result = op_a + op_b;
            alu_type[ALU_SUB]:  result = op_a - op_b;
            alu_type[ALU_SLT]:  result = XLEN'(lt_s);
            alu_type[ALU_SLTU]: result = XLEN'(lt_u);
            alu_type[ALU_XOR]:  result = op_a ^ op_b;
            alu_type[ALU_OR]:   result = op_a | op_b;
            alu_type[ALU_AND]:  result = op_a & op_b;
            alu_type[ALU_SLL]:  result = op_a << shamt;
            alu_type[ALU_SRL]:  result = op_a >> shamt;
            alu_type[ALU_SRA]:  result = $unsigned($signed(op_a) >>> shamt);
            alu_type[ALU_EQ],
            alu_type[ALU_NEQ],
            alu_type[ALU_LT],
            alu_type[ALU_GE],
            alu_type[ALU_LTU],
            alu_type[ALU_GEU]:  result = XLEN'(cmp);
            default:            result = '0;
        endcase
    end

endmodule

// File: rtl/execute.sv
// RV32I execute stage: forwarding, ALU, branch/jump resolution, registered results to memoryaccess.
// One-cycle latency; incoming stall freezes the stage, load-use inserts a one-cycle bubble.
module execute
    import execute_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     rst,
    execute_if.slave bus
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rd_data;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] next_pc;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        opcode_t         opcode_type;
        exc_t            exception;
    } stage_t;

    stage_t          q;
    stage_t          d;
    logic            clk_en_q;
    logic            wr_rd_q;
    logic            change_pc_q;

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_result;
    logic            alu_cmp;
    logic [XLEN-1:0] rd_val;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    opcode_t         op;
    logic            no_exc;
    logic            use_rs1;
    logic            use_rs2;
    logic            hazard;
    logic            valid;
    logic            redirect;

    assign op      = bus.decode_opcode_type;
    assign no_exc  = (bus.decode_exception == '0);
    assign use_rs1 = |(op & RS1_READERS);
    assign use_rs2 = |(op & RS2_READERS);

    // memoryaccess is younger than writeback, so its value wins on a double match.
    always_comb begin
        rs1_val = bus.rs1_data;
        if (bus.decode_rs1 == '0)
            rs1_val = '0;
        else if (bus.memoryaccess_wr_rd && bus.memoryaccess_rd == bus.decode_rs1)
            rs1_val = bus.memoryaccess_rd_data;
        else if (bus.writeback_wr_rd && bus.writeback_rd == bus.decode_rs1)
            rs1_val = bus.writeback_rd_data;
    end

    always_comb begin
        rs2_val = bus.rs2_data;
        if (bus.decode_rs2 == '0)
            rs2_val = '0;
        else if (bus.memoryaccess_wr_rd && bus.memoryaccess_rd == bus.decode_rs2)
            rs2_val = bus.memoryaccess_rd_data;
        else if (bus.writeback_wr_rd && bus.writeback_rd == bus.decode_rs2)
            rs2_val = bus.writeback_rd_data;
    end

    // Load data is not available until writeback, so the consumer waits one cycle.
    assign hazard = bus.clk_en && bus.memoryaccess_is_load && bus.memoryaccess_wr_rd &&
                    (bus.memoryaccess_rd != '0) &&
                    ((use_rs1 && bus.memoryaccess_rd == bus.decode_rs1) ||
                     (use_rs2 && bus.memoryaccess_rd == bus.decode_rs2));

    assign op_b = |(op & IMM_OPERAND) ? bus.decode_imm : rs2_val;

    execute_alu #(
        .XLEN(XLEN)
    ) u_alu (
        .op_a     (rs1_val),
        .op_b     (op_b),
        .alu_type (bus.decode_alu_type),
        .result   (alu_result),
        .cmp      (alu_cmp)
    );

    always_comb begin
        rd_val = alu_result;
        if (op[OP_JAL] || op[OP_JALR])
            rd_val = bus.decode_pc + XLEN'(4);
        else if (op[OP_LUI])
            rd_val = bus.decode_imm;
        else if (op[OP_AUIPC])
            rd_val = bus.decode_pc + bus.decode_imm;
    end

    assign jalr_sum = rs1_val + bus.decode_imm;
    assign target   = op[OP_JALR] ? {jalr_sum[XLEN-1:1], 1'b0} : bus.decode_pc + bus.decode_imm;

    assign valid    = bus.clk_en && !hazard;
    assign redirect = valid && no_exc &&
                      ((op[OP_BRANCH] && alu_cmp) || op[OP_JAL] || op[OP_JALR]);

    always_comb begin
        d             = '0;
        d.pc          = bus.decode_pc;
        d.rd_data     = rd_val;
        d.result      = alu_result;
        d.rs2_data    = rs2_val;
        d.next_pc     = target;
        d.rd          = bus.decode_rd;
        d.funct3      = bus.decode_funct3;
        d.opcode_type = op;
        d.exception   = bus.decode_exception;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q           <= '0;
            clk_en_q    <= 1'b0;
            wr_rd_q     <= 1'b0;
            change_pc_q <= 1'b0;
        end else begin
            if (!bus.stall)
                q <= d;
            // change_pc is a pulse: it never survives into a stalled or flushed cycle.
            if (bus.flush) begin
                clk_en_q    <= 1'b0;
                wr_rd_q     <= 1'b0;
                change_pc_q <= 1'b0;
            end else if (bus.stall) begin
                change_pc_q <= 1'b0;
            end else begin
                clk_en_q    <= valid;
                wr_rd_q     <= valid && |(op & RD_WRITERS) && (bus.decode_rd != '0) && no_exc;
                change_pc_q <= redirect;
            end
        end
    end

    assign bus.execute_pc          = q.pc;
    assign bus.execute_rd          = q.rd;
    assign bus.execute_wr_rd       = wr_rd_q;
    assign bus.execute_rd_data     = q.rd_data;
    assign bus.execute_result      = q.result;
    assign bus.execute_rs2_data    = q.rs2_data;
    assign bus.execute_funct3      = q.funct3;
    assign bus.execute_opcode_type = q.opcode_type;
    assign bus.execute_exception   = q.exception;
    assign bus.execute_change_pc   = change_pc_q;
    assign bus.execute_next_pc     = q.next_pc;
    assign bus.next_clk_en         = clk_en_q;
    assign bus.next_stall          = bus.stall | hazard;
    assign bus.next_flush          = bus.flush | change_pc_q;

endmodule

// File: tb/tb_execute.sv
// Directed plus randomized bench for the execute stage against an instruction-level reference model.
module tb_execute;
    import execute_pkg::*;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    execute_if bus ();

    execute dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Current instruction in abstract form.
    int cur_cls;
    int cur_aop;

    // Expected registered state.
    logic [31:0] e_pc, e_rd_data, e_result, e_rs2, e_npc;
    logic [4:0]  e_rd;
    logic [2:0]  e_f3;
    logic [10:0] e_op;
    logic [3:0]  e_exc;
    logic        e_wr, e_cpc, e_ce;
    logic        obs_stall;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input int aop, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (aop)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:  return a ^ b;
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            ALU_SLL:  return a << sh;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return $unsigned($signed(a) >>> sh);
            ALU_EQ:   return (a == b) ? 32'd1 : 32'd0;
            ALU_NEQ:  return (a != b) ? 32'd1 : 32'd0;
            ALU_LT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_GE:   return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
            ALU_LTU:  return (a < b) ? 32'd1 : 32'd0;
            ALU_GEU:  return (a >= b) ? 32'd1 : 32'd0;
            default:  return 32'd0;
        endcase
    endfunction

    // Newest in-flight producer of a register wins over older ones and the regfile.
    function automatic logic [31:0] ref_src(input logic [4:0] r, input logic [31:0] rf);
        logic [31:0] v;
        v = rf;
        if (bus.writeback_wr_rd && bus.writeback_rd == r) v = bus.writeback_rd_data;
        if (bus.memoryaccess_wr_rd && bus.memoryaccess_rd == r) v = bus.memoryaccess_rd_data;
        if (r == 5'd0) v = 32'd0;
        return v;
    endfunction

    task automatic zero_model();
        e_pc = 0; e_rd_data = 0; e_result = 0; e_rs2 = 0; e_npc = 0;
        e_rd = 0; e_f3 = 0; e_op = 0; e_exc = 0; e_wr = 0; e_cpc = 0; e_ce = 0;
    endtask

    task automatic compare_all(input string tag);
        check({tag, "/pc"},        bus.execute_pc,          e_pc);
        check({tag, "/rd"},        32'(bus.execute_rd),     32'(e_rd));
        check({tag, "/wr_rd"},     32'(bus.execute_wr_rd),  32'(e_wr));
        check({tag, "/rd_data"},   bus.execute_rd_data,     e_rd_data);
        check({tag, "/result"},    bus.execute_result,      e_result);
        check({tag, "/rs2_data"},  bus.execute_rs2_data,    e_rs2);
        check({tag, "/funct3"},    32'(bus.execute_funct3), 32'(e_f3));
        check({tag, "/opcode"},    32'(bus.execute_opcode_type), 32'(e_op));
        check({tag, "/exception"}, 32'(bus.execute_exception),   32'(e_exc));
        check({tag, "/change_pc"}, 32'(bus.execute_change_pc),   32'(e_cpc));
        check({tag, "/next_pc"},   bus.execute_next_pc,     e_npc);
        check({tag, "/clk_en"},    32'(bus.next_clk_en),    32'(e_ce));
    endtask

    task automatic set_instr(input int cls, input int aop, input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [31:0] imm, input logic [31:0] pc,
                             input logic [31:0] d1, input logic [31:0] d2);
        cur_cls = cls;
        cur_aop = aop;
        bus.decode_opcode_type      = '0;
        bus.decode_opcode_type[cls] = 1'b1;
        bus.decode_alu_type         = '0;
        bus.decode_alu_type[aop]    = 1'b1;
        bus.decode_rd     = rd;
        bus.decode_rs1    = rs1;
        bus.decode_rs2    = rs2;
        bus.decode_imm    = imm;
        bus.decode_pc     = pc;
        bus.decode_funct3 = 3'(aop);
        bus.rs1_data      = d1;
        bus.rs2_data      = d2;
    endtask

    task automatic quiet_side();
        bus.memoryaccess_rd      = 0;
        bus.memoryaccess_wr_rd   = 0;
        bus.memoryaccess_is_load = 0;
        bus.memoryaccess_rd_data = 0;
        bus.writeback_rd         = 0;
        bus.writeback_wr_rd      = 0;
        bus.writeback_rd_data    = 0;
        bus.decode_exception     = 0;
        bus.stall                = 0;
        bus.flush                = 0;
        bus.clk_en               = 1;
    endtask

    // Apply the current inputs for one clock and check against the model.
    task automatic step(input string tag);
        logic        u1, u2, hz, valid, jump, taken, writes;
        logic [31:0] a, b2, b, alu, rdv, tgt;
        u1 = cur_cls inside {OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
        u2 = cur_cls inside {OP_RTYPE, OP_STORE, OP_BRANCH};
        writes = cur_cls inside {OP_RTYPE, OP_ITYPE, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
        hz = bus.clk_en && bus.memoryaccess_is_load && bus.memoryaccess_wr_rd &&
             (bus.memoryaccess_rd != 0) &&
             ((u1 && bus.memoryaccess_rd == bus.decode_rs1) || (u2 && bus.memoryaccess_rd == bus.decode_rs2));
        #1;
        obs_stall = bus.next_stall;
        check({tag, "/next_stall"}, 32'(bus.next_stall), 32'(bus.stall | hz));
        check({tag, "/next_flush"}, 32'(bus.next_flush), 32'(bus.flush | e_cpc));

        a  = ref_src(bus.decode_rs1, bus.rs1_data);
        b2 = ref_src(bus.decode_rs2, bus.rs2_data);
        b  = (cur_cls inside {OP_ITYPE, OP_LOAD, OP_STORE, OP_JALR}) ? bus.decode_imm : b2;
        alu = ref_alu(cur_aop, a, b);
        case (cur_cls)
            OP_JAL, OP_JALR: rdv = bus.decode_pc + 4;
            OP_LUI:          rdv = bus.decode_imm;
            OP_AUIPC:        rdv = bus.decode_pc + bus.decode_imm;
            default:         rdv = alu;
        endcase
        tgt   = (cur_cls == OP_JALR) ? ((a + bus.decode_imm) & ~32'd1) : bus.decode_pc + bus.decode_imm;
        jump  = cur_cls inside {OP_JAL, OP_JALR};
        taken = (cur_cls == OP_BRANCH) && (alu == 32'd1);

        if (!bus.stall) begin
            e_pc = bus.decode_pc; e_rd = bus.decode_rd; e_rd_data = rdv; e_result = alu;
            e_rs2 = b2; e_f3 = bus.decode_funct3; e_op = bus.decode_opcode_type;
            e_exc = bus.decode_exception; e_npc = tgt;
        end
        if (bus.flush) begin
            e_ce = 0; e_wr = 0; e_cpc = 0;
        end else if (bus.stall) begin
            e_cpc = 0;
        end else begin
            valid = bus.clk_en && !hz;
            e_ce  = valid;
            e_wr  = valid && writes && (bus.decode_rd != 0) && (bus.decode_exception == 0);
            e_cpc = valid && (bus.decode_exception == 0) && (jump || taken);
        end
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    int classes [9] = '{OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

    initial begin
        int cls, aop;
        rst = 1'b0;
        quiet_side();
        set_instr(OP_ITYPE, ALU_ADD, 5'd2, 5'd0, 5'd0, 32'd150, 32'h0, 32'h0, 32'h0);

        // Reset held two cycles with a valid instruction presented.
        repeat (2) @(posedge clk);
        #1;
        zero_model();
        compare_all("reset");
        check("reset/next_flush", 32'(bus.next_flush), 32'd0);
        check("reset/next_stall", 32'(bus.next_stall), 32'd0);
        rst = 1'b1;

        // ADDI x2, x0, 150
        step("addi");
        check("addi/rd", 32'(bus.execute_rd), 32'd2);
        check("addi/rd_data", bus.execute_rd_data, 32'h96);
        check("addi/wr_rd", 32'(bus.execute_wr_rd), 32'd1);

        // Forwarding priority.
        bus.memoryaccess_rd = 5; bus.memoryaccess_wr_rd = 1; bus.memoryaccess_rd_data = 32'h11;
        bus.writeback_rd = 5; bus.writeback_wr_rd = 1; bus.writeback_rd_data = 32'h22;
        set_instr(OP_RTYPE, ALU_ADD, 5'd6, 5'd5, 5'd0, 32'h0, 32'h4, 32'h99, 32'h0);
        step("fwd_ma");
        check("fwd_ma/value", bus.execute_rd_data, 32'h11);
        bus.memoryaccess_wr_rd = 0;
        step("fwd_wb");
        check("fwd_wb/value", bus.execute_rd_data, 32'h22);
        bus.decode_rs1 = 0;
        step("fwd_x0");
        check("fwd_x0/value", bus.execute_rd_data, 32'h0);

        // Load-use: one bubble, then the instruction completes from writeback.
        quiet_side();
        bus.memoryaccess_rd = 7; bus.memoryaccess_wr_rd = 1; bus.memoryaccess_is_load = 1;
        set_instr(OP_RTYPE, ALU_ADD, 5'd8, 5'd7, 5'd0, 32'h0, 32'h8, 32'h1, 32'h0);
        step("lu_hz");
        check("lu_hz/stall_seen", 32'(obs_stall), 32'd1);
        check("lu_hz/bubble", 32'(bus.next_clk_en), 32'd0);
        check("lu_hz/no_wr", 32'(bus.execute_wr_rd), 32'd0);
        bus.memoryaccess_is_load = 0; bus.memoryaccess_wr_rd = 0;
        bus.writeback_rd = 7; bus.writeback_wr_rd = 1; bus.writeback_rd_data = 32'h55;
        step("lu_go");
        check("lu_go/stall_seen", 32'(obs_stall), 32'd0);
        check("lu_go/clk_en", 32'(bus.next_clk_en), 32'd1);
        check("lu_go/rd_data", bus.execute_rd_data, 32'h55);

        // Taken BEQ then one-cycle pulse.
        quiet_side();
        set_instr(OP_BRANCH, ALU_EQ, 5'd0, 5'd1, 5'd2, 32'd8, 32'h10, 32'hAB, 32'hAB);
        step("beq_t");
        check("beq_t/change_pc", 32'(bus.execute_change_pc), 32'd1);
        check("beq_t/next_pc", bus.execute_next_pc, 32'h18);
        check("beq_t/next_flush", 32'(bus.next_flush), 32'd1);
        bus.rs2_data = 32'hAC;
        step("beq_nt");
        check("beq_nt/change_pc", 32'(bus.execute_change_pc), 32'd0);

        // JALR x1, 4(x3)
        set_instr(OP_JALR, ALU_ADD, 5'd1, 5'd3, 5'd0, 32'd4, 32'h20, 32'h101, 32'h0);
        step("jalr");
        check("jalr/next_pc", bus.execute_next_pc, 32'h104);
        check("jalr/rd_data", bus.execute_rd_data, 32'h24);
        check("jalr/change_pc", 32'(bus.execute_change_pc), 32'd1);

        // Flush beats a taken branch.
        set_instr(OP_BRANCH, ALU_EQ, 5'd0, 5'd1, 5'd2, 32'd8, 32'h30, 32'h5, 32'h5);
        bus.flush = 1;
        step("flush_br");
        check("flush_br/change_pc", 32'(bus.execute_change_pc), 32'd0);
        check("flush_br/clk_en", 32'(bus.next_clk_en), 32'd0);
        bus.flush = 0;

        // Stall held three cycles freezes the stage.
        set_instr(OP_ITYPE, ALU_ADD, 5'd9, 5'd0, 5'd0, 32'h77, 32'h40, 32'h0, 32'h0);
        step("pre_stall");
        set_instr(OP_ITYPE, ALU_ADD, 5'd10, 5'd0, 5'd0, 32'h5, 32'h44, 32'h0, 32'h0);
        bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            step("stall");
            check("stall/rd_data", bus.execute_rd_data, 32'h77);
            check("stall/rd", 32'(bus.execute_rd), 32'd9);
        end
        bus.stall = 0;
        step("unstall");

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            cls = classes[$urandom_range(0, 8)];
            if (cls == OP_RTYPE || cls == OP_ITYPE) aop = $urandom_range(0, 9);
            else if (cls == OP_BRANCH)              aop = $urandom_range(10, 15);
            else                                    aop = ALU_ADD;
            set_instr(cls, aop, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)),
                      ($urandom_range(0, 1) == 1) ? $urandom() : 32'($signed(12'($urandom()))),
                      {$urandom_range(0, 4095), 2'b00},
                      ($urandom_range(0, 3) == 0) ? bus.rs2_data : $urandom(), $urandom());
            bus.memoryaccess_rd      = 5'($urandom_range(0, 7));
            bus.memoryaccess_wr_rd   = 1'($urandom_range(0, 1));
            bus.memoryaccess_is_load = ($urandom_range(0, 3) == 0);
            bus.memoryaccess_rd_data = $urandom();
            bus.writeback_rd         = 5'($urandom_range(0, 7));
            bus.writeback_wr_rd      = 1'($urandom_range(0, 1));
            bus.writeback_rd_data    = $urandom();
            bus.decode_exception     = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            bus.stall                = ($urandom_range(0, 7) == 0);
            bus.flush                = ($urandom_range(0, 9) == 0);
            bus.clk_en               = ($urandom_range(0, 7) != 0);
            step("rand");
        end

        // Mid-run reset clears a pending redirect.
        quiet_side();
        set_instr(OP_JAL, ALU_ADD, 5'd1, 5'd0, 5'd0, 32'h100, 32'h80, 32'h0, 32'h0);
        step("jal");
        check("jal/change_pc", 32'(bus.execute_change_pc), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        zero_model();
        compare_all("mid_reset");
        rst = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/execute.md
Name: execute

Overview:
- Third pipeline stage of the RV32I 5-stage core. Sits between decode and memoryaccess.
- Consumes decode's registered instruction fields plus register-file read data, and resolves operands with forwarding from memoryaccess and writeback.
- Computes ALU results, branch/jump targets and link values.
- Registers the results toward memoryaccess. Drives execute_change_pc/execute_next_pc back to fetch and a flush to fetch/decode.

Parameters:
- XLEN, 32, datapath width; only 32 supported.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-low (rst==0 resets on posedge clk)
- decode_pc  in  32  PC of the instruction in execute
- decode_rs1  in  5  rs1 index
- decode_rs2  in  5  rs2 index
- decode_rd  in  5  rd index
- decode_imm  in  32  sign-extended immediate
- decode_funct3  in  3  funct3
- decode_alu_type  in  `ALU_WIDTH  one-hot ALU op
- decode_opcode_type  in  `OPCODE_WIDTH  one-hot opcode class
- decode_exception  in  `EXCEPTION_WIDTH  exceptions raised upstream
- rs1_data  in  32  register-file value for decode_rs1
- rs2_data  in  32  register-file value for decode_rs2
- memoryaccess_rd  in  5  rd of the instruction in memoryaccess
- memoryaccess_wr_rd  in  1  memoryaccess will write rd
- memoryaccess_is_load  in  1  memoryaccess instruction is a load
- memoryaccess_rd_data  in  32  memoryaccess forward value
- writeback_rd  in  5  rd of the instruction in writeback
- writeback_wr_rd  in  1  writeback writes rd
- writeback_rd_data  in  32  writeback forward value
- execute_pc  out  32  registered PC
- execute_rd  out  5  registered rd
- execute_wr_rd  out  1  registered rd-write enable
- execute_rd_data  out  32  registered rd value (non-load)
- execute_result  out  32  ALU result / load-store address
- execute_rs2_data  out  32  forwarded rs2 (store data)
- execute_funct3  out  3  registered funct3
- execute_opcode_type  out  `OPCODE_WIDTH  registered opcode class
- execute_exception  out  `EXCEPTION_WIDTH  registered exceptions
- execute_change_pc  out  1  registered redirect pulse
- execute_next_pc  out  32  redirect target
- clk_en  in  1  decode outputs valid
- next_clk_en  out  1  execute outputs valid
- stall  in  1  stall from downstream
- next_stall  out  1  stall to decode/fetch
- flush  in  1  flush from downstream
- next_flush  out  1  flush to decode/fetch

Behaviour:
- Reset: all outputs 0, including next_clk_en, execute_change_pc and next_flush.
- Latency: one cycle from decode fields to execute_* registers.

Operand forwarding (combinational), per rs:
- Index 0 always yields 0.
- Otherwise use memoryaccess if memoryaccess_wr_rd and rd matches; else writeback if writeback_wr_rd and rd matches; else regfile data.
- memoryaccess has priority over writeback.

Load-use hazard:
- Triggered when clk_en && memoryaccess_is_load && memoryaccess_wr_rd && memoryaccess_rd!=0 && memoryaccess_rd matches a used rs.
- Action: next_stall=1 and a bubble is inserted: next_clk_en=0 and execute_wr_rd=0 next cycle.
- Hazard clears after one cycle, once the load moves to writeback.

Stall/flush:
- next_stall = stall | hazard.
- On stall (incoming), all execute_* registers hold.
- flush has highest priority: registered next_clk_en=0, wr_rd=0, change_pc=0.

Operand B:
- imm for ITYPE/LOAD/STORE/JALR.
- rs2 otherwise.

ALU:
- ADD, SUB, XOR, OR, AND.
- SLT signed, SLTU unsigned.
- SLL/SRL/SRA use op_b[4:0].
- EQ/NEQ/LT/GE/LTU/GEU give 1-bit compare results for branches.

rd_data by opcode:
- JAL/JALR: pc+4
- LUI: imm
- AUIPC: pc+imm
- otherwise: ALU result
- All arithmetic is mod 2^32.

Targets:
- BRANCH/JAL: pc+imm.
- JALR: (rs1+imm) & ~1.
- execute_change_pc=1 for exactly one cycle after a valid, unflushed, unstalled, exception-free taken branch or any jump.

Flush out:
- next_flush = flush | execute_change_pc, so fetch/decode drop their two younger instructions.

Write enable:
- execute_wr_rd = clk_en && writes-rd class && decode_rd!=0 && decode_exception==0.

Exceptions:
- decode_exception is propagated unchanged; no redirect when it is non-zero.

Mid-operation reset clears everything, including a pending change_pc.

Decomposition:
- Shared package/header: ALU_WIDTH and one-hot indices, OPCODE_WIDTH and one-hot indices, EXCEPTION_WIDTH and bit indices. These are shared with decode and memoryaccess.
- One combinational sub-module, alu: op_a, op_b, alu_type -> result, compare bit.

Test Plan:
1. Reset: rst=0 for 2 cycles with clk_en=1 -> all outputs 0. After release and a valid ADDI x2,x0,150 (0x09600113), next cycle execute_rd=2, execute_rd_data=0x96, wr_rd=1.
2. Forwarding: memoryaccess writes x5=0x11, writeback writes x5=0x22; issue ADD x6,x5,x0 -> rd_data=0x11. With memoryaccess_wr_rd=0 -> 0x22. With rs1=0 -> 0.
3. Load-use: memoryaccess_is_load, rd=7; issue ADD using x7 -> next_stall=1 for one cycle, bubble (next_clk_en=0). Instruction completes the following cycle.
4. Branch: BEQ at pc 0x10, imm 8, rs1==rs2 -> execute_change_pc=1 for one cycle, next_pc=0x18, next_flush=1. With rs1!=rs2 -> no redirect.
5. JALR: rs1=0x101, imm 4, pc 0x20 -> next_pc=0x104, rd_data=0x24.
6. Simultaneous flush plus taken branch -> no change_pc, next_clk_en=0. Also: stall held 3 cycles -> outputs frozen.
